ddr2_cmd_replay_buffer: RTL and testbench

//  Go-back-N replay buffer between the command CRC front-end and ddr2_controller.
//  - Stores each CRC-tagged host command until downstream CRC feedback acks it.
//  - Issues queued commands in order.
//  - On a CRC error, re-issues every unacked command from the oldest one,
//    up to a retry limit; past the limit it latches a fatal RAS flag.

---
 rtl/ddr2_cmd_replay_buffer.sv | 133 +++++++++++++
 tb/tb_ddr2_cmd_replay_buffer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_cmd_replay_buffer.sv
// Go-back-N replay buffer between the command CRC front-end and ddr2_controller.
// Holds each issued command until CRC feedback acks it; replays from the oldest unacked command on error.
module ddr2_cmd_replay_buffer #(
   parameter int ADDR_WIDTH = 25,
   parameter int CRC_WIDTH  = 8,
   parameter int DEPTH      = 4,
   parameter int MAX_RETRY  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            in_cmd,
   input  logic [1:0]            in_sz,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [CRC_WIDTH-1:0]  in_crc,
   input  logic                  in_put,
   output logic                  in_full,
   output logic [2:0]            out_cmd,
   output logic [1:0]            out_sz,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [CRC_WIDTH-1:0]  out_crc,
   output logic                  out_put,
   output logic                  out_retry,
   input  logic                  out_ready,
   input  logic                  fb_valid,
   input  logic                  fb_error,
   output logic                  fatal,
   output logic                  fb_unexp,
   output logic [15:0]           err_count
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam int EW = 3 + 2 + ADDR_WIDTH + CRC_WIDTH;
   localparam int RW = $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {RUN, REPLAY, FATAL} state_t;

   state_t state, state_nx;

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, iss_ptr, ack_ptr, replay_end;
   logic [RW-1:0] retry_cnt;

   logic full, outstanding, pending, fb_err_raw, fb_apply;
   logic do_write, do_issue, ok_now, err_now, limit_hit;

   // Outstanding = [ack, iss), pending = [iss, wr); pointers carry one extra wrap bit.
   always_comb begin
      full        = (wr_ptr - ack_ptr) == PW'(DEPTH);
      in_full     = full | fatal;
      outstanding = ack_ptr != iss_ptr;
      pending     = iss_ptr != wr_ptr;
      fb_err_raw  = fb_valid & fb_error;
      fb_apply    = fb_valid & outstanding & (state != FATAL);
      do_write    = in_put & ~in_full;
      do_issue    = (state != FATAL) & pending & out_ready & ~fb_err_raw;
      ok_now      = fb_apply & ~fb_error;
      err_now     = fb_apply & fb_error;
      limit_hit   = err_now & (retry_cnt >= RW'(MAX_RETRY));

      state_nx = state;
      case (state)
         RUN: begin
            if (err_now) state_nx = limit_hit ? FATAL : REPLAY;
         end
         REPLAY: begin
            if (err_now)                      state_nx = limit_hit ? FATAL : REPLAY;
            else if (iss_ptr == replay_end)   state_nx = RUN;
         end
         default: state_nx = FATAL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= state_nx;
   end

   // Entry storage needs no reset: pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr[IW-1:0]] <= {in_cmd, in_sz, in_addr, in_crc};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         iss_ptr    <= '0;
         ack_ptr    <= '0;
         replay_end <= '0;
         retry_cnt  <= '0;
         fatal      <= 1'b0;
         fb_unexp   <= 1'b0;
         err_count  <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + PW'(1);

         // While already replaying, replay_end never moves back since iss never passes it.
         if (err_now && !limit_hit) begin
            iss_ptr   <= ack_ptr;
            retry_cnt <= retry_cnt + RW'(1);
            if (state == RUN) replay_end <= iss_ptr;
         end else if (do_issue) begin
            iss_ptr <= iss_ptr + PW'(1);
         end

         if (ok_now) begin
            ack_ptr   <= ack_ptr + PW'(1);
            retry_cnt <= '0;
         end

         if (err_now && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         if (limit_hit) fatal <= 1'b1;
         if (fb_valid && !outstanding && state != FATAL) fb_unexp <= 1'b1;
      end
   end

   // Command fields hold their last issued value between strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_cmd   <= '0;
         out_sz    <= '0;
         out_addr  <= '0;
         out_crc   <= '0;
         out_put   <= 1'b0;
         out_retry <= 1'b0;
      end else begin
         out_put   <= do_issue;
         out_retry <= do_issue && (state == REPLAY) && (iss_ptr != replay_end);
         if (do_issue) {out_cmd, out_sz, out_addr, out_crc} <= mem[iss_ptr[IW-1:0]];
      end
   end

endmodule

// File: tb/tb_ddr2_cmd_replay_buffer.sv
// Self-checking bench for ddr2_cmd_replay_buffer: directed scenarios plus a random run
// against a queue-based model of the go-back-N buffer.
module tb_ddr2_cmd_replay_buffer;

   localparam int AW = 25;
   localparam int CW = 8;
   localparam int DEPTH = 4;
   localparam int MAX_RETRY = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    in_cmd;
   logic [1:0]    in_sz;
   logic [AW-1:0] in_addr;
   logic [CW-1:0] in_crc;
   logic          in_put;
   logic          in_full;
   logic [2:0]    out_cmd;
   logic [1:0]    out_sz;
   logic [AW-1:0] out_addr;
   logic [CW-1:0] out_crc;
   logic          out_put;
   logic          out_retry;
   logic          out_ready;
   logic          fb_valid;
   logic          fb_error;
   logic          fatal;
   logic          fb_unexp;
   logic [15:0]   err_count;

   always #5 clk = ~clk;

   ddr2_cmd_replay_buffer #(
      .ADDR_WIDTH(AW), .CRC_WIDTH(CW), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .reset(reset),
      .in_cmd(in_cmd), .in_sz(in_sz), .in_addr(in_addr), .in_crc(in_crc),
      .in_put(in_put), .in_full(in_full),
      .out_cmd(out_cmd), .out_sz(out_sz), .out_addr(out_addr), .out_crc(out_crc),
      .out_put(out_put), .out_retry(out_retry), .out_ready(out_ready),
      .fb_valid(fb_valid), .fb_error(fb_error),
      .fatal(fatal), .fb_unexp(fb_unexp), .err_count(err_count)
   );

   typedef struct packed {
      logic [2:0]    cmd;
      logic [1:0]    sz;
      logic [AW-1:0] addr;
      logic [CW-1:0] crc;
   } ent_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: m_q holds every unacked entry oldest first; the first m_issued of
   // them are outstanding, and m_rem of the next ones still count as replays.
   ent_t m_q[$];
   int   m_issued, m_rem, m_retry, m_errc;
   bit   m_fatal, m_unexp;
   bit   e_put, e_retry;
   ent_t e_out;

   ent_t seen_e[$];
   bit   seen_r[$];
   int   seen_c[$];

   function automatic ent_t rand_ent();
      ent_t e;
      e.cmd  = 3'($urandom);
      e.sz   = 2'($urandom);
      e.addr = AW'($urandom);
      e.crc  = CW'($urandom);
      return e;
   endfunction

   function automatic ent_t cur_in();
      ent_t e;
      e.cmd = in_cmd; e.sz = in_sz; e.addr = in_addr; e.crc = in_crc;
      return e;
   endfunction

   task automatic set_in(input ent_t e);
      in_cmd = e.cmd; in_sz = e.sz; in_addr = e.addr; in_crc = e.crc;
   endtask

   task automatic idle_inputs();
      in_put = 0; out_ready = 0; fb_valid = 0; fb_error = 0;
      set_in('0);
   endtask

   task automatic model_step();
      bit err_raw, full_m, issue;
      int iss0;
      if (reset) begin
         m_q.delete();
         m_issued = 0; m_rem = 0; m_retry = 0; m_errc = 0;
         m_fatal = 0; m_unexp = 0;
         e_put = 0; e_retry = 0; e_out = '0;
         return;
      end
      err_raw = fb_valid && fb_error;
      full_m  = (m_q.size() == DEPTH) || m_fatal;
      iss0    = m_issued;
      issue   = !m_fatal && (m_q.size() > m_issued) && out_ready && !err_raw;
      e_put   = issue;
      e_retry = 0;
      if (issue) begin
         e_out   = m_q[iss0];
         e_retry = (m_rem > 0);
         m_issued++;
         if (m_rem > 0) m_rem--;
      end
      if (in_put && !full_m) m_q.push_back(cur_in());
      if (fb_valid && !m_fatal) begin
         if (iss0 == 0) m_unexp = 1;
         else if (!fb_error) begin
            void'(m_q.pop_front());
            m_issued--;
            m_retry = 0;
         end else begin
            if (m_errc < 65535) m_errc++;
            if (m_retry < MAX_RETRY) begin
               m_rem    = m_rem + iss0;
               m_issued = 0;
               m_retry++;
            end else begin
               m_fatal = 1;
            end
         end
      end
   endtask

   // One clock: advance the model on the pre-edge inputs, then sample #1 after the edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      if (out_put) begin
         seen_e.push_back({out_cmd, out_sz, out_addr, out_crc});
         seen_r.push_back(out_retry);
         seen_c.push_back(cyc);
      end
   endtask

   task automatic clear_seen();
      seen_e.delete(); seen_r.delete(); seen_c.delete();
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      tick();
      reset = 0;
      clear_seen();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      tick(); tick();
      checks++;
      if ({out_put, out_retry, fatal, fb_unexp, in_full} !== 5'b0 || err_count !== 16'd0 ||
          {out_cmd, out_sz, out_addr, out_crc} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_state got put=%b retry=%b fatal=%b unexp=%b full=%b errc=%0d out=%h want all zero",
                  out_put, out_retry, fatal, fb_unexp, in_full, err_count, {out_cmd, out_sz, out_addr, out_crc});
      end
      reset = 0;
      clear_seen();
   endtask

   task automatic test_in_order();
      ent_t exp[3];
      do_reset();
      foreach (exp[i]) exp[i] = rand_ent();
      out_ready = 1;
      in_put = 1;
      for (int i = 0; i < 3; i++) begin set_in(exp[i]); tick(); end
      in_put = 0;
      repeat (3) tick();
      checks++;
      if (seen_e.size() != 3) begin
         errors++; $display("[TB] FAIL in_order_count got %0d want 3", seen_e.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (seen_e[i] !== exp[i] || seen_r[i] !== 1'b0) begin
               errors++;
               $display("[TB] FAIL in_order_entry%0d got %h/r%b want %h/r0", i, seen_e[i], seen_r[i], exp[i]);
            end
         end
         checks++;
         if (seen_c[2] - seen_c[0] != 2) begin
            errors++; $display("[TB] FAIL in_order_spacing got %0d want 2", seen_c[2] - seen_c[0]);
         end
      end
      fb_valid = 1; fb_error = 0;
      repeat (3) tick();
      fb_valid = 0;
      tick();
      checks++;
      if (err_count !== 16'd0 || in_full !== 1'b0 || fb_unexp !== 1'b0) begin
         errors++;
         $display("[TB] FAIL in_order_acked got errc=%0d full=%b unexp=%b want 0/0/0", err_count, in_full, fb_unexp);
      end
   endtask

   task automatic test_full();
      ent_t exp[4];
      ent_t extra;
      do_reset();
      foreach (exp[i]) exp[i] = rand_ent();
      extra = rand_ent();
      in_put = 1;
      for (int i = 0; i < 4; i++) begin set_in(exp[i]); tick(); end
      checks++;
      if (in_full !== 1'b1) begin errors++; $display("[TB] FAIL full_flag got %b want 1", in_full); end
      set_in(extra);
      tick();
      in_put = 0;
      out_ready = 1;
      repeat (6) tick();
      checks++;
      if (seen_e.size() != 4) begin
         errors++; $display("[TB] FAIL full_drop_count got %0d want 4", seen_e.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen_e[i] !== exp[i]) begin
               errors++; $display("[TB] FAIL full_entry%0d got %h want %h", i, seen_e[i], exp[i]);
            end
         end
      end
      checks++;
      if (in_full !== 1'b1) begin errors++; $display("[TB] FAIL full_after_issue got %b want 1", in_full); end
      fb_valid = 1; fb_error = 0;
      tick();
      fb_valid = 0;
      checks++;
      if (in_full !== 1'b0) begin errors++; $display("[TB] FAIL full_after_ack got %b want 0", in_full); end
   endtask

   task automatic test_replay();
      ent_t exp[4];
      bit   rexp[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      foreach (exp[i]) exp[i] = rand_ent();
      out_ready = 1;
      in_put = 1;
      for (int i = 0; i < 3; i++) begin set_in(exp[i]); tick(); end
      in_put = 0;
      repeat (3) tick();
      clear_seen();
      fb_valid = 1; fb_error = 1;
      tick();
      fb_valid = 0; fb_error = 0;
      in_put = 1; set_in(exp[3]);
      tick();
      in_put = 0;
      repeat (8) tick();
      checks++;
      if (seen_e.size() != 4) begin
         errors++; $display("[TB] FAIL replay_count got %0d want 4", seen_e.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen_e[i] !== exp[i] || seen_r[i] !== rexp[i]) begin
               errors++;
               $display("[TB] FAIL replay_entry%0d got %h/r%b want %h/r%b", i, seen_e[i], seen_r[i], exp[i], rexp[i]);
            end
         end
      end
      checks++;
      if (err_count !== 16'd1) begin errors++; $display("[TB] FAIL replay_errc got %0d want 1", err_count); end
   endtask

   task automatic test_fatal();
      do_reset();
      out_ready = 1;
      in_put = 1; set_in(rand_ent());
      tick();
      in_put = 0;
      repeat (3) tick();
      for (int k = 1; k <= 4; k++) begin
         fb_valid = 1; fb_error = 1;
         tick();
         fb_valid = 0; fb_error = 0;
         checks++;
         if (fatal !== (k == 4)) begin
            errors++; $display("[TB] FAIL fatal_after_err%0d got %b want %b", k, fatal, k == 4);
         end
         repeat (3) tick();
      end
      checks++;
      if (in_full !== 1'b1 || err_count !== 16'd4) begin
         errors++; $display("[TB] FAIL fatal_state got full=%b errc=%0d want 1/4", in_full, err_count);
      end
      clear_seen();
      in_put = 1; set_in(rand_ent());
      fb_valid = 1;
      tick();
      in_put = 0; fb_valid = 0;
      repeat (4) tick();
      checks++;
      if (seen_e.size() != 0 || err_count !== 16'd4 || fatal !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fatal_frozen got puts=%0d errc=%0d fatal=%b want 0/4/1", seen_e.size(), err_count, fatal);
      end
   endtask

   task automatic test_unexpected();
      ent_t a;
      do_reset();
      a = rand_ent();
      fb_valid = 1; fb_error = 0;
      tick();
      fb_valid = 0;
      checks++;
      if (fb_unexp !== 1'b1 || err_count !== 16'd0 || in_full !== 1'b0 || out_put !== 1'b0) begin
         errors++;
         $display("[TB] FAIL unexp_flag got unexp=%b errc=%0d full=%b put=%b want 1/0/0/0",
                  fb_unexp, err_count, in_full, out_put);
      end
      out_ready = 1;
      in_put = 1; set_in(a);
      tick();
      in_put = 0;
      repeat (3) tick();
      checks++;
      if (seen_e.size() != 1 || seen_e[0] !== a || seen_r[0] !== 1'b0) begin
         errors++; $display("[TB] FAIL unexp_then_issue got n=%0d want one entry %h non-retry", seen_e.size(), a);
      end
   endtask

   task automatic test_reset_mid();
      ent_t d;
      do_reset();
      d = rand_ent();
      fb_valid = 1;
      tick();
      fb_valid = 0;
      out_ready = 1;
      in_put = 1;
      repeat (3) begin set_in(rand_ent()); tick(); end
      in_put = 0;
      repeat (3) tick();
      fb_valid = 1; fb_error = 1;
      tick();
      fb_valid = 0; fb_error = 0;
      tick();
      reset = 1;
      tick();
      reset = 0;
      checks++;
      if ({out_put, out_retry, fatal, fb_unexp, in_full} !== 5'b0 || err_count !== 16'd0 ||
          {out_cmd, out_sz, out_addr, out_crc} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid got put=%b retry=%b unexp=%b errc=%0d out=%h want all zero",
                  out_put, out_retry, fb_unexp, err_count, {out_cmd, out_sz, out_addr, out_crc});
      end
      clear_seen();
      in_put = 1; set_in(d);
      tick();
      in_put = 0;
      repeat (4) tick();
      checks++;
      if (seen_e.size() != 1 || seen_e[0] !== d || seen_r[0] !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_mid_issue got n=%0d want one entry %h non-retry", seen_e.size(), d);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 800; i++) begin
         reset     = ($urandom_range(99) < 1);
         in_put    = ($urandom_range(99) < 55);
         out_ready = ($urandom_range(99) < 70);
         fb_valid  = ($urandom_range(99) < 35);
         fb_error  = ($urandom_range(99) < 15);
         if (m_fatal && $urandom_range(99) < 20) reset = 1;
         set_in(rand_ent());
         tick();
         checks++;
         if (out_put !== e_put || out_retry !== e_retry || {out_cmd, out_sz, out_addr, out_crc} !== e_out) begin
            errors++;
            $display("[TB] FAIL random_issue cycle %0d got put=%b retry=%b out=%h want put=%b retry=%b out=%h",
                     i, out_put, out_retry, {out_cmd, out_sz, out_addr, out_crc}, e_put, e_retry, e_out);
         end
         reset = 0;
         checks++;
         if (in_full !== ((m_q.size() == DEPTH) || m_fatal) || fatal !== m_fatal ||
             fb_unexp !== m_unexp || err_count !== 16'(m_errc)) begin
            errors++;
            $display("[TB] FAIL random_status cycle %0d got full=%b fatal=%b unexp=%b errc=%0d want %b/%b/%b/%0d",
                     i, in_full, fatal, fb_unexp, err_count,
                     (m_q.size() == DEPTH) || m_fatal, m_fatal, m_unexp, m_errc);
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      test_reset();
      test_in_order();
      test_full();
      test_replay();
      test_fatal();
      test_unexpected();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
